piso_tx: RTL and testbench

- Parallel-in serial-out transmitter, the driving end of the team's `sipo` 4-bit deserializer.
- Captures a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock.
- Frames are gapless when the producer keeps `load_valid` high.
- Sits between a word source (CPU register or FIFO) and a serial link terminated by `sipo`.

---
 rtl/piso_tx.sv | 156 +++++++++++++++
 tb/tb_piso_tx.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter, the driving end of the sipo
// deserializer. A WIDTH-bit word is taken over a valid/ready handshake and sent
// one bit per clock; frames run back to back while load_valid stays high.
//
// Optional feature: define PISO_PARITY_EN to append one parity bit per frame
// (even parity, or odd when ODD_PARITY=1). Without it ODD_PARITY is unused.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   load_valid   producer presents a word on parallel_in
//   load_ready   block accepts a word this cycle (decoded from state only)
//   parallel_in  word to send, sampled only on handshake
//   serial_out   current serial bit (registered)
//   serial_valid serial_out carries a frame bit (registered)
//   busy         frame in progress, same as serial_valid
//   done         pulse coincident with the final bit of each frame (registered)
module piso_tx #(
  parameter int WIDTH      = 4,
  parameter int MSB_FIRST  = 1,
  parameter int ODD_PARITY = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] parallel_in,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(WIDTH - 1);

  // Reject illegal configurations at elaboration.
  if (WIDTH < 2 || ODD_PARITY < 0 || ODD_PARITY > 1) begin : g_bad_param
    $error("piso_tx: WIDTH must be >= 2 and ODD_PARITY 0 or 1");
  end

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t           state_q, state_n;
  logic [WIDTH-1:0] shreg_q, shreg_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             serial_out_n, serial_valid_n, done_n;
  logic             accept;
`ifdef PISO_PARITY_EN
  logic             par_q, par_n;
`endif

  // Bit that leaves the word first in the configured order.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  // Move the next bit of the word into the leading position.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
  endfunction

  // Ready when idle or while the final frame bit is on the wire.
`ifdef PISO_PARITY_EN
  assign load_ready = (state_q == IDLE) || (state_q == PARITY);
`else
  assign load_ready = (state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == LAST_DATA));
`endif

  assign accept = load_valid && load_ready;
  assign busy   = serial_valid;

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
      done         <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_n;
      shreg_q      <= shreg_n;
      cnt_q        <= cnt_n;
      serial_out   <= serial_out_n;
      serial_valid <= serial_valid_n;
      done         <= done_n;
`ifdef PISO_PARITY_EN
      par_q        <= par_n;
`endif
    end
  end

  // Next-state and next-output decode; outputs are the values for the next cycle.
  always_comb begin
    state_n        = state_q;
    shreg_n        = shreg_q;
    cnt_n          = cnt_q;
    serial_out_n   = 1'b0;
    serial_valid_n = 1'b0;
    done_n         = 1'b0;
`ifdef PISO_PARITY_EN
    par_n          = par_q;
`endif

    if (accept) begin
      // New frame: first bit goes out next cycle, rest stays in the shifter.
      state_n        = SHIFT;
      cnt_n          = '0;
      shreg_n        = advance(parallel_in);
      serial_out_n   = first_bit(parallel_in);
      serial_valid_n = 1'b1;
`ifdef PISO_PARITY_EN
      par_n          = (^parallel_in) ^ (ODD_PARITY != 0);
`endif
    end else begin
      case (state_q)
        SHIFT: begin
          if (cnt_q == LAST_DATA) begin
`ifdef PISO_PARITY_EN
            state_n        = PARITY;
            cnt_n          = CNT_W'(cnt_q + CNT_W'(1));
            serial_out_n   = par_q;
            serial_valid_n = 1'b1;
            done_n         = 1'b1;
`else
            state_n        = IDLE;
`endif
          end else begin
            cnt_n          = CNT_W'(cnt_q + CNT_W'(1));
            shreg_n        = advance(shreg_q);
            serial_out_n   = first_bit(shreg_q);
            serial_valid_n = 1'b1;
`ifndef PISO_PARITY_EN
            // Flag the cycle that will carry the last data bit.
            done_n         = (CNT_W'(cnt_q + CNT_W'(1)) == LAST_DATA);
`endif
          end
        end
`ifdef PISO_PARITY_EN
        PARITY: state_n = IDLE;
`endif
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: two instances (MSB-first and LSB-first) share stimulus.
// The driver pushes each accepted frame's expected bit stream into a queue; a
// negedge monitor pops one entry per cycle and compares the serial outputs.
module tb_piso_tx;

  localparam int W   = 4;
  localparam int ODD = 0;
`ifdef PISO_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  typedef struct packed {
    logic bit_v;
    logic last;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         load_valid = 1'b0;
  logic [W-1:0] parallel_in = '0;
  logic         ready_m, out_m, valid_m, busy_m, done_m;
  logic         ready_l, out_l, valid_l, busy_l, done_l;

  exp_t q_m[$];
  exp_t q_l[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(W), .MSB_FIRST(1), .ODD_PARITY(ODD)) dut_m (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(ready_m),
    .parallel_in(parallel_in), .serial_out(out_m), .serial_valid(valid_m),
    .busy(busy_m), .done(done_m)
  );

  piso_tx #(.WIDTH(W), .MSB_FIRST(0), .ODD_PARITY(ODD)) dut_l (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(ready_l),
    .parallel_in(parallel_in), .serial_out(out_l), .serial_valid(valid_l),
    .busy(busy_l), .done(done_l)
  );

  task automatic chk(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame: data bits in the configured order, optional parity, done on last.
  task automatic push_frame(input logic [W-1:0] d);
    for (int i = 0; i < W; i++) begin
      q_m.push_back('{bit_v: d[W-1-i], last: (i == FL - 1)});
      q_l.push_back('{bit_v: d[i],     last: (i == FL - 1)});
    end
`ifdef PISO_PARITY_EN
    begin
      logic p;
      p = 1'b0;
      for (int i = 0; i < W; i++) p = p ^ d[i];
      if (ODD != 0) p = ~p;
      q_m.push_back('{bit_v: p, last: 1'b1});
      q_l.push_back('{bit_v: p, last: 1'b1});
    end
`endif
  endtask

  // One cycle of stimulus, applied just after the monitor has consumed this cycle.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic r);
    @(negedge clk);
    #1;
    reset       = r;
    load_valid  = v;
    parallel_in = d;
    if (r) begin
      q_m.delete();
      q_l.delete();
    end else if (v && q_m.size() == 0) begin
      push_frame(d);
    end
  endtask

  // Monitor: compare each instance against the head of its expected stream.
  always @(negedge clk) begin
    exp_t em, el;
    logic ev, exp_rdy;
    if (mon_en) begin
      exp_rdy = (q_m.size() <= 1);
      chk("load_ready_msb", ready_m, exp_rdy);
      chk("load_ready_lsb", ready_l, exp_rdy);
      ev = (q_m.size() > 0);
      em = ev ? q_m.pop_front() : exp_t'(0);
      el = (q_l.size() > 0) ? q_l.pop_front() : exp_t'(0);
      chk("valid_msb", valid_m, ev);
      chk("busy_msb",  busy_m,  ev);
      chk("out_msb",   out_m,   em.bit_v);
      chk("done_msb",  done_m,  em.last);
      chk("valid_lsb", valid_l, ev);
      chk("busy_lsb",  busy_l,  ev);
      chk("out_lsb",   out_l,   el.bit_v);
      chk("done_lsb",  done_l,  el.last);
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1;
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);

    // Single frame, then idle.
    cycle(1'b1, 4'b1011, 1'b0);
    repeat (FL + 2) cycle(1'b0, 4'b0000, 1'b0);

    // Back-to-back: second word held until it is accepted on the last bit.
    cycle(1'b1, 4'b1011, 1'b0);
    repeat (FL) cycle(1'b1, 4'b0110, 1'b0);
    repeat (FL + 2) cycle(1'b0, 4'b0000, 1'b0);

    // Reset after two bits, then a clean frame.
    cycle(1'b1, 4'b1111, 1'b0);
    repeat (2) cycle(1'b0, 4'b1111, 1'b0);
    cycle(1'b1, 4'b1010, 1'b1);
    cycle(1'b1, 4'b0001, 1'b0);
    repeat (FL + 2) cycle(1'b0, 4'b0000, 1'b0);

    // Random traffic with occasional resets and changing data.
    for (int k = 0; k < 3000; k++) begin
      cycle($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 99) == 0);
    end

    repeat (FL + 2) cycle(1'b0, 4'b0000, 1'b0);
    chk("drain_msb", q_m.size() == 0, 1'b1);
    chk("drain_lsb", q_l.size() == 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
